// File: rtl/fact_scheduler.sv
// Round-robin scheduler sharing one factorial unit between NREQ requesters.
// Grants one requester at a time, issues its operand with a one-cycle go,
// waits for done or a timeout, then returns the result with a one-cycle ack.
module fact_scheduler #(
    parameter int NREQ    = 4,
    parameter int DW      = 4,
    parameter int RW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] n_in,
    output logic [NREQ-1:0]    ack,
    output logic [RW-1:0]      res_out,
    output logic               err,
    output logic               fu_go,
    output logic [DW-1:0]      fu_n,
    input  logic               fu_done,
    input  logic [RW-1:0]      fu_result
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } state_t;

    state_t         state, state_d;
    logic [IW-1:0]  gnt_idx, gnt_idx_d;
    logic [IW-1:0]  ptr, ptr_d;
    logic [DW-1:0]  n_q, n_q_d;
    logic [15:0]    timer, timer_d;
    logic [RW-1:0]  res_q, res_q_d;
    logic           err_q, err_q_d;
    logic [NREQ-1:0] ack_d;
    logic           fu_go_d;
    logic [DW-1:0]  fu_n_d;

    logic [IW-1:0]  sel_idx;
    logic           sel_valid;
    int unsigned    cand;

    // Round-robin pick: first requesting index at or above ptr, wrapping
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr) + k) % 32'(NREQ);
            if (!sel_valid && req[IW'(cand)]) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(cand);
            end
        end
    end

    // Next-state logic; outputs are derived from the next state so they register as Moore outputs
    always_comb begin
        state_d   = state;
        gnt_idx_d = gnt_idx;
        ptr_d     = ptr;
        n_q_d     = n_q;
        timer_d   = timer;
        res_q_d   = res_q;
        err_q_d   = err_q;

        case (state)
            IDLE: begin
                if (sel_valid) begin
                    gnt_idx_d = sel_idx;
                    n_q_d     = n_in[32'(sel_idx) * DW +: DW];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = BUSY;
            end
            BUSY: begin
                timer_d = timer + 16'd1;
                // done takes priority over a timeout landing in the same cycle
                if (fu_done) begin
                    res_q_d = fu_result;
                    err_q_d = 1'b0;
                    state_d = RESP;
                end else if (timer == 16'(TIMEOUT - 1)) begin
                    res_q_d = '0;
                    err_q_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        fu_go_d = (state_d == ISSUE);
        fu_n_d  = (state_d == ISSUE || state_d == BUSY) ? n_q_d : '0;
        ack_d   = '0;
        if (state_d == RESP) begin
            ack_d[gnt_idx_d] = 1'b1;
        end
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_idx <= '0;
            ptr     <= '0;
            n_q     <= '0;
            timer   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            ack     <= '0;
            fu_go   <= 1'b0;
            fu_n    <= '0;
        end else begin
            state   <= state_d;
            gnt_idx <= gnt_idx_d;
            ptr     <= ptr_d;
            n_q     <= n_q_d;
            timer   <= timer_d;
            res_q   <= res_q_d;
            err_q   <= err_q_d;
            ack     <= ack_d;
            fu_go   <= fu_go_d;
            fu_n    <= fu_n_d;
        end
    end

    assign res_out = res_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fact_scheduler.sv
// Self-checking bench for fact_scheduler: a transaction-level model of the
// scheduler and factorial unit predicts every output each cycle; directed
// tables and sequences cover latency, ordering, fairness, timeout and reset.
module tb_fact_scheduler;

    localparam int NREQ  = 4;
    localparam int DW    = 4;
    localparam int RW    = 32;
    localparam int TO    = 8;
    localparam int NEVER = 1000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] n_in = '0;
    logic [NREQ-1:0]    ack;
    logic [RW-1:0]      res_out;
    logic               err;
    logic               fu_go;
    logic [DW-1:0]      fu_n;
    logic               fu_done = 1'b0;
    logic [RW-1:0]      fu_result = '0;

    always #5 clk = ~clk;

    fact_scheduler #(.NREQ(NREQ), .DW(DW), .RW(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .n_in(n_in), .ack(ack),
        .res_out(res_out), .err(err), .fu_go(fu_go), .fu_n(fu_n),
        .fu_done(fu_done), .fu_result(fu_result)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    bit          inflight = 0;
    int          m_ptr = 0, m_gnt = 0, m_n = 0;
    int          go_cyc = -1, ack_cyc = -1, done_cyc = -1, free_cyc = 0;
    logic [31:0] op_res = '0, hold_res = '0;
    logic        op_err = 1'b0, hold_err = 1'b0;

    // observed DUT completions
    int              dut_ack_cnt = 0;
    int              last_ack_cyc = 0;
    logic [NREQ-1:0] last_ack_vec = '0;
    logic [31:0]     last_res = '0;
    logic            last_err = 1'b0;
    int              dut_served[$];
    logic [31:0]     dut_res[$];

    // stimulus controls
    int rq_left[NREQ];
    bit rand_mode = 0;
    int fixed_lat = 2;

    typedef struct {
        int          idx;
        int          n;
        int          lat;
        int          delay;
        logic [31:0] res;
        logic        e;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [31:0] fact(int n);
        longint unsigned f = 1;
        for (int i = 2; i <= n; i++) f = f * longint'(i);
        return f[31:0];
    endfunction

    function automatic int pick(logic [NREQ-1:0] r, int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(int i);
        logic [NREQ-1:0] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: model decision for the current cycle, edge, compare, react
    task automatic step();
        int g, lat, eff;
        bit is_ack;
        if (rst) begin
            inflight = 0; m_ptr = 0;
            go_cyc = -1; ack_cyc = -1; done_cyc = -1;
            free_cyc = cyc + 1;
            hold_res = '0; hold_err = 1'b0;
        end else if (!inflight && cyc >= free_cyc) begin
            g = pick(req, m_ptr);
            if (g >= 0) begin
                lat = rand_mode ? (($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TO - 1)))
                                : fixed_lat;
                eff      = (lat >= TO) ? TO - 1 : lat;
                m_gnt    = g;
                m_n      = int'(n_in[g*DW +: DW]);
                inflight = 1;
                go_cyc   = cyc + 1;
                ack_cyc  = cyc + 3 + eff;
                op_err   = (lat >= TO);
                op_res   = op_err ? 32'd0 : fact(m_n);
                done_cyc = (lat >= TO) ? -1 : cyc + 2 + lat;
            end
        end

        @(posedge clk);
        #1;
        cyc++;

        is_ack = inflight && (cyc == ack_cyc);
        chk("fu_go", 64'(fu_go), 64'(inflight && cyc == go_cyc));
        chk("fu_n", 64'(fu_n), (inflight && cyc >= go_cyc && cyc < ack_cyc) ? 64'(m_n) : 64'd0);
        chk("ack", 64'(ack), is_ack ? 64'(onehot(m_gnt)) : 64'd0);
        chk("res_out", 64'(res_out), is_ack ? 64'(op_res) : 64'(hold_res));
        chk("err", 64'(err), is_ack ? 64'(op_err) : 64'(hold_err));

        if (ack != '0) begin
            dut_ack_cnt++;
            last_ack_cyc = cyc;
            last_ack_vec = ack;
            last_res     = res_out;
            last_err     = err;
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    dut_served.push_back(i);
                    break;
                end
            end
            dut_res.push_back(res_out);
        end

        if (is_ack) begin
            hold_res = op_res;
            hold_err = op_err;
            m_ptr    = (m_gnt + 1) % NREQ;
            inflight = 0;
            free_cyc = cyc + 1;
            if (req[m_gnt]) begin
                rq_left[m_gnt]--;
                if (rq_left[m_gnt] > 0) n_in[m_gnt*DW +: DW] = DW'($urandom_range(0, 15));
                else req[m_gnt] = 1'b0;
            end
        end

        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 15) == 0) begin
                    req[i]     = 1'b1;
                    rq_left[i] = int'($urandom_range(1, 3));
                    n_in[i*DW +: DW] = DW'($urandom_range(0, 15));
                end
            end
            // a granted requester may walk away; its ack still arrives
            if (inflight && req[m_gnt] && $urandom_range(0, 31) == 0) begin
                req[m_gnt]     = 1'b0;
                rq_left[m_gnt] = 0;
            end
            rst = ($urandom_range(0, 399) == 0);
        end

        if (cyc == done_cyc) begin
            fu_done   = 1'b1;
            fu_result = fact(m_n);
        end else begin
            fu_done   = rand_mode && !inflight && ($urandom_range(0, 3) == 0);
            fu_result = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int k = 0;
        while ((inflight || req != '0) && k < budget) begin
            step();
            k++;
        end
        if (inflight || req != '0) begin
            checks++; errors++;
            $display("FAIL wait_idle: scheduler still busy after %0d cycles", budget);
        end
        step();
        step();
    endtask

    task automatic run_until_served(int cnt, int budget, string what);
        int k = 0;
        while (dut_served.size() < cnt && k < budget) begin
            step();
            k++;
        end
        if (dut_served.size() < cnt) begin
            checks++; errors++;
            $display("FAIL %s: only %0d of %0d acks within %0d cycles", what, dut_served.size(), cnt, budget);
        end
    endtask

    initial begin
        int t0, c0, k;
        logic [NREQ-1:0] want;
        int exp_sim[4];
        logic [31:0] exp_sim_res[4];
        int exp_fair[8];
        int exp_rst[2];

        tbl[0] = '{idx: 1, n: 5,  lat: 3,     delay: 6,  res: 32'd120,        e: 1'b0};
        tbl[1] = '{idx: 3, n: 0,  lat: 0,     delay: 3,  res: 32'd1,          e: 1'b0};
        tbl[2] = '{idx: 0, n: 4,  lat: 6,     delay: 9,  res: 32'd24,         e: 1'b0};
        tbl[3] = '{idx: 2, n: 6,  lat: 7,     delay: 10, res: 32'd720,        e: 1'b0};
        tbl[4] = '{idx: 1, n: 3,  lat: NEVER, delay: 10, res: 32'd0,          e: 1'b1};
        tbl[5] = '{idx: 2, n: 7,  lat: 1,     delay: 4,  res: 32'd5040,       e: 1'b0};
        tbl[6] = '{idx: 0, n: 12, lat: 2,     delay: 5,  res: 32'd479001600,  e: 1'b0};
        tbl[7] = '{idx: 3, n: 13, lat: 4,     delay: 7,  res: 32'd1932053504, e: 1'b0};
        exp_sim     = '{0, 1, 2, 3};
        exp_sim_res = '{32'd1, 32'd2, 32'd6, 32'd24};
        exp_fair    = '{0, 2, 0, 2, 0, 2, 0, 2};
        exp_rst     = '{1, 3};
        for (int i = 0; i < NREQ; i++) rq_left[i] = 0;

        do_reset();
        chk("reset_ack", 64'(ack), 64'd0);
        chk("reset_fu_go", 64'(fu_go), 64'd0);
        chk("reset_res", 64'(res_out), 64'd0);

        // single requests: latency, result, timeout and done/timeout collision
        for (int v = 0; v < 8; v++) begin
            wait_idle(100);
            fixed_lat = tbl[v].lat;
            n_in[tbl[v].idx*DW +: DW] = DW'(tbl[v].n);
            req[tbl[v].idx]     = 1'b1;
            rq_left[tbl[v].idx] = 1;
            t0 = cyc;
            c0 = dut_ack_cnt;
            k  = 0;
            while (dut_ack_cnt == c0 && k < 40) begin
                step();
                k++;
            end
            if (dut_ack_cnt == c0) begin
                checks++; errors++;
                $display("FAIL vec%0d_no_ack: no ack within 40 cycles", v);
            end else begin
                want = onehot(tbl[v].idx);
                chk($sformatf("vec%0d_ack", v), 64'(last_ack_vec), 64'(want));
                chk($sformatf("vec%0d_delay", v), 64'(last_ack_cyc - t0), 64'(tbl[v].delay));
                chk($sformatf("vec%0d_res", v), 64'(last_res), 64'(tbl[v].res));
                chk($sformatf("vec%0d_err", v), 64'(last_err), 64'(tbl[v].e));
            end
        end

        // simultaneous requests after reset: served in index order
        wait_idle(100);
        do_reset();
        fixed_lat = 2;
        for (int i = 0; i < NREQ; i++) begin
            n_in[i*DW +: DW] = DW'(i + 1);
            rq_left[i] = 1;
        end
        req = '1;
        dut_served.delete();
        dut_res.delete();
        run_until_served(4, 100, "simultaneous");
        for (int i = 0; i < 4 && i < dut_served.size(); i++) begin
            chk($sformatf("sim_order%0d", i), 64'(dut_served[i]), 64'(exp_sim[i]));
            chk($sformatf("sim_res%0d", i), 64'(dut_res[i]), 64'(exp_sim_res[i]));
        end

        // fairness: two requesters held continuously must alternate
        wait_idle(100);
        fixed_lat = 1;
        rq_left[0] = 4; rq_left[2] = 4;
        n_in[0*DW +: DW] = DW'(3);
        n_in[2*DW +: DW] = DW'(4);
        req[0] = 1'b1; req[2] = 1'b1;
        dut_served.delete();
        run_until_served(8, 200, "fairness");
        for (int i = 0; i < 8 && i < dut_served.size(); i++)
            chk($sformatf("fair%0d", i), 64'(dut_served[i]), 64'(exp_fair[i]));

        // reset mid-BUSY: ptr returns to 0, pending requests re-arbitrate from there
        wait_idle(100);
        fixed_lat = 1;
        n_in[2*DW +: DW] = DW'(2);
        req[2] = 1'b1; rq_left[2] = 1;
        wait_idle(100);
        fixed_lat = NEVER;
        n_in[3*DW +: DW] = DW'(5);
        n_in[1*DW +: DW] = DW'(3);
        req[3] = 1'b1; rq_left[3] = 1;
        req[1] = 1'b1; rq_left[1] = 1;
        c0 = dut_ack_cnt;
        repeat (4) step();
        chk("rst_busy_fu_n", 64'(fu_n), 64'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_no_ack_cnt", 64'(dut_ack_cnt), 64'(c0));
        chk("rst_fu_n", 64'(fu_n), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        fixed_lat = 2;
        dut_served.delete();
        run_until_served(2, 60, "after_reset");
        for (int i = 0; i < 2 && i < dut_served.size(); i++)
            chk($sformatf("rst_order%0d", i), 64'(dut_served[i]), 64'(exp_rst[i]));

        // randomized traffic against the model, including spurious done and random resets
        wait_idle(100);
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        rst = 1'b0;
        wait_idle(500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fact_scheduler.md
# fact_scheduler

Round-robin scheduler that shares one factorial unit (controller plus counter/multiplier datapath with `go`/`done` handshake) between `NREQ` requesters. It grants the unit to one requester at a time and issues that requester's operand with a one-cycle `go`. It then waits for `done` or a timeout and returns the result with a one-cycle acknowledge. It sits between the client blocks and the factorial unit, which it alone drives.

## Interface
- `NREQ`, 4, number of requesters (legal 2..8)
- `DW`, 4, operand width
- `RW`, 32, result width
- `TIMEOUT`, 255, maximum BUSY cycles before abort (legal 1..2^16-1)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req`  in  NREQ  per-requester request level
- `n_in`  in  NREQ*DW  operands; requester i at bits [i*DW +: DW]
- `ack`  out  NREQ  one-cycle completion pulse to the granted requester
- `res_out`  out  RW  result, valid in the `ack` cycle
- `err`  out  1  timeout flag, valid in the `ack` cycle
- `fu_go`  out  1  start pulse to the factorial unit
- `fu_n`  out  DW  operand to the factorial unit
- `fu_done`  in  1  completion pulse from the factorial unit
- `fu_result`  in  RW  factorial unit result, valid with `fu_done`

## Operation
- **Outputs.** All outputs are registered (Moore).
- **State.** States are IDLE, ISSUE, BUSY, RESP. Internal registers are `gnt_idx`, `ptr` (round-robin start), `n_q`, `timer` (16 bits) and `res_q`.
- **IDLE.**
  - If any `req` bit is high, select the first set bit searching upward from `ptr` and wrapping modulo NREQ.
  - Latch `gnt_idx` and `n_q` from that requester's slice of `n_in`, then go to ISSUE.
  - If no request is present, stay in IDLE.
- **ISSUE.** `fu_go`=1 for exactly this cycle and `timer` clears to 0. Go to BUSY.
- **BUSY.**
  - `timer` increments each cycle.
  - If `fu_done`=1, capture `fu_result` into `res_q`, set `err`=0 and go to RESP.
  - Otherwise, if `timer`==TIMEOUT-1, set `res_q`=0, `err`=1 and go to RESP.
  - If `fu_done` and the timeout coincide, `fu_done` wins (`err`=0).
- **RESP.** `ack[gnt_idx]`=1 for exactly this cycle. `res_out`=`res_q` and `err` are presented. `ptr` becomes (`gnt_idx`+1) mod NREQ. Go to IDLE.
- **`fu_n`.** Driven from `n_q` in ISSUE and BUSY, and 0 otherwise.
- **Requester protocol.**
  - A requester holds `req` and `n_in` stable until its `ack`.
  - A requester that keeps `req` high after `ack` is treated as a new request. It ranks last under the updated `ptr`.
  - Dropping `req` after it has been granted does not cancel the operation; `ack` is still issued.
- **Ignored inputs.** `req` changes outside IDLE are ignored, as are `fu_done` pulses outside BUSY.
- **Held values.** `res_out` and `err` hold their last RESP values until the next RESP, but are only meaningful while some `ack` bit is high. At most one `ack` bit is ever high.
- **Unit availability.** The factorial unit returns to its idle state one cycle after `done`. RESP→IDLE→ISSUE spans 2 cycles, so `go` always reaches an idle unit.

## Timing
- **Reset values** (while `rst`=1 at a clock edge):
  - state=IDLE, `ptr`=0, `gnt_idx`=0, `timer`=0, `n_q`=0, `res_q`=0
  - `ack`=0, `res_out`=0, `err`=0, `fu_go`=0, `fu_n`=0
- **Reset mid-operation.** Abort with no `ack` issued. The factorial unit shares `rst` and resets with the scheduler.
- **Latency.** Request seen in IDLE at cycle 0. Cycle 1: ISSUE (`fu_go` high). Cycle 2 on: BUSY. `fu_done` at cycle k gives `ack` at cycle k+1.
- **Throughput.** Back-to-back grants are separated by exactly one IDLE cycle after RESP.
- **Timeout.** `fu_done` never arrives: `ack` with `err`=1 occurs at cycle 2+TIMEOUT.

## Test plan
- **Single request.** Reset, then `req[1]`=1 with n=5; factorial unit model answers. Expect `fu_go` one cycle with `fu_n`=5, then `ack`=4'b0010 for one cycle, `res_out`=120 and `err`=0.
- **Simultaneous requests.** After reset, all four `req` high with n=1,2,3,4 and held until each requester's own `ack`. Expect service order 0,1,2,3 with results 1,2,6,24, and exactly one IDLE cycle between RESP and the next ISSUE.
- **Fairness.** `req[0]` and `req[2]` held continuously. Expect grants to alternate 0,2,0,2 over 8 operations; neither requester is served twice in a row.
- **Timeout.** Factorial unit model never asserts `fu_done`, TIMEOUT=8. Expect `ack` at cycle 10 after the request, `err`=1, `res_out`=0, and the next request served normally.
- **Done/timeout collision.** `fu_done` asserted in the same cycle as `timer`==TIMEOUT-1 with `fu_result`=720. Expect `err`=0 and `res_out`=720.
- **Reset mid-BUSY.** `rst` pulsed during BUSY. Expect no `ack`, all outputs 0, state IDLE and `ptr`=0. A still-pending `req[3]` is then granted normally.
